interp_linear: RTL

Parametrised resampling interpolator for signed sample streams. Each input sample (`i_ce`) advances a phase accumulator by `i_step`. On every accumulator carry it emits one output sample: either the current input (nearest-neighbour mode) or a linear blend of the previous and current inputs, weighted by the phase fraction (linear mode). It sits between a sample source and a slower output-rate consumer in the signal chain. It adds a synchronous reset, a configurable interpolation mode and a fixed 3-cycle pipelined datapath.

---
 rtl/interp_linear.sv | 121 ++++++++++++
 1 files changed

// File: rtl/interp_linear.sv
// rtl/interp_linear.sv - phase-accumulator resampler with 3-stage linear/nearest interpolation
module interp_linear #(
    parameter int INW        = 28,
    parameter int CTRBITS    = 32,
    parameter int FRACBITS   = 12,
    parameter int OPT_LINEAR = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [CTRBITS-1:0] i_step,
    input  logic [INW-1:0]     i_data,
    output logic               o_ce,
    output logic [INW-1:0]     o_data
);

    // Product of a (INW+1)-bit signed difference and a (FRACBITS+1)-bit non-negative weight.
    localparam int PW = INW + FRACBITS + 2;
    localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) << (FRACBITS - 1);

    logic [CTRBITS-1:0]     counter_q, counter_d;
    logic [INW-1:0]         last_q, last_d;
    logic                   v1_q, v1_d;
    logic [INW-1:0]         base_q, base_d;
    logic [INW-1:0]         cur_q, cur_d;
    logic [INW:0]           diff_q, diff_d;
    logic [FRACBITS-1:0]    mu1_q, mu1_d;
    logic                   v2_q, v2_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic [INW-1:0]         base2_q, base2_d;
    logic [INW-1:0]         cur2_q, cur2_d;
    logic                   oce_q, oce_d;
    logic [INW-1:0]         odata_q, odata_d;

    logic [CTRBITS:0]       sum;
    logic signed [PW-1:0]   diff_ext;
    logic signed [PW-1:0]   mu_ext;
    logic signed [PW-1:0]   shifted;
    logic [INW-1:0]         lin_val;
    logic                   unused_shift_hi;

    // Stage 1: advance the phase accumulator and capture the sample pair plus its weight.
    always_comb begin
        sum       = {1'b0, counter_q} + {1'b0, i_step};
        counter_d = counter_q;
        last_d    = last_q;
        v1_d      = 1'b0;
        base_d    = base_q;
        cur_d     = cur_q;
        diff_d    = diff_q;
        mu1_d     = mu1_q;
        if (i_ce) begin
            counter_d = sum[CTRBITS-1:0];
            last_d    = i_data;
            v1_d      = sum[CTRBITS];
            base_d    = last_q;
            cur_d     = i_data;
            diff_d    = {i_data[INW-1], i_data} - {last_q[INW-1], last_q};
            mu1_d     = sum[CTRBITS-1 -: FRACBITS];
        end
    end

    // Stage 2: signed difference times unsigned weight; operands widened to the full product width.
    always_comb begin
        diff_ext = {{(PW-INW-1){diff_q[INW]}}, diff_q};
        mu_ext   = {{(PW-FRACBITS){1'b0}}, mu1_q};
        v2_d     = v1_q;
        prod_d   = diff_ext * mu_ext;
        base2_d  = base_q;
        cur2_d   = cur_q;
    end

    // Stage 3: round half toward +inf, add to the older sample, hold output between pulses.
    always_comb begin
        shifted         = (prod_q + ROUND_HALF) >>> FRACBITS;
        unused_shift_hi = ^shifted[PW-1:INW];
        lin_val         = base2_q + shifted[INW-1:0];
        oce_d           = v2_q;
        odata_d         = odata_q;
        if (v2_q) begin
            odata_d = (OPT_LINEAR != 0) ? lin_val : cur2_q;
        end
    end

    // All state registers; reset clears the accumulator, history sample, valids and output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter_q <= '0;
            last_q    <= '0;
            v1_q      <= 1'b0;
            base_q    <= '0;
            cur_q     <= '0;
            diff_q    <= '0;
            mu1_q     <= '0;
            v2_q      <= 1'b0;
            prod_q    <= '0;
            base2_q   <= '0;
            cur2_q    <= '0;
            oce_q     <= 1'b0;
            odata_q   <= '0;
        end else begin
            counter_q <= counter_d;
            last_q    <= last_d;
            v1_q      <= v1_d;
            base_q    <= base_d;
            cur_q     <= cur_d;
            diff_q    <= diff_d;
            mu1_q     <= mu1_d;
            v2_q      <= v2_d;
            prod_q    <= prod_d;
            base2_q   <= base2_d;
            cur2_q    <= cur2_d;
            oce_q     <= oce_d;
            odata_q   <= odata_d;
        end
    end

    assign o_ce   = oce_q;
    assign o_data = odata_q;

endmodule
